// File: rtl/fetch_unit.sv
// Instruction fetch with a 2-entry {PC, instr} queue toward decode.
// Optional halt-on-all-ones via `define FETCH_HALT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Clear,
  output logic [31:0] ReadPC,
  input  logic [31:0] MemInstr,
  input  logic        BranchEn,
  input  logic [31:0] BranchTarget,
  input  logic        Ready,
  output logic        Valid,
  output logic [31:0] InstrOut,
  output logic [31:0] PCOut,
  output logic        Halted
);

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {
    IDLE, RUN, HALT
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, RUN
  } state_t;
`endif

  state_t      state_q;
  logic [9:0]  pc_q;
  logic [1:0]  cnt_q;
  logic [9:0]  pc0_q, pc1_q;
  logic [31:0] ins0_q, ins1_q;
  logic        push, pop;
  logic        unused_tgt;

  assign unused_tgt = ^BranchTarget[31:10];

  assign ReadPC   = {22'd0, pc_q};
  assign Valid    = (cnt_q != 2'd0);
  assign InstrOut = ins0_q;
  assign PCOut    = {22'd0, pc0_q};

  // a full queue may still fetch when decode drains the head
  always_comb begin
    pop  = Valid && Ready;
    push = !BranchEn && (state_q == RUN)
           && ((cnt_q != 2'd2) || Ready);
  end

`ifdef FETCH_HALT_EN
  logic halted_q;
  assign Halted = halted_q;
`else
  assign Halted = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC[9:0];
      cnt_q   <= 2'd0;
      pc0_q   <= 10'd0;
      pc1_q   <= 10'd0;
      ins0_q  <= 32'd0;
      ins1_q  <= 32'd0;
`ifdef FETCH_HALT_EN
      halted_q <= 1'b0;
`endif
    end else if (BranchEn) begin
      state_q <= RUN;
      pc_q    <= BranchTarget[9:0];
      cnt_q   <= 2'd0;
`ifdef FETCH_HALT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: state_q <= RUN;
`ifdef FETCH_HALT_EN
        RUN: begin
          if (push && (MemInstr == 32'hFFFF_FFFF)) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end
        end
`endif
        default: ;
      endcase

      if (push) pc_q <= pc_q + 10'd1;

      case (cnt_q)
        2'd0: begin
          if (push) begin
            pc0_q  <= pc_q;
            ins0_q <= MemInstr;
            cnt_q  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            pc0_q  <= pc_q;
            ins0_q <= MemInstr;
          end else if (push) begin
            pc1_q  <= pc_q;
            ins1_q <= MemInstr;
            cnt_q  <= 2'd2;
          end else if (pop) begin
            cnt_q  <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            pc0_q  <= pc1_q;
            ins0_q <= ins1_q;
            if (push) begin
              pc1_q  <= pc_q;
              ins1_q <= MemInstr;
            end else begin
              cnt_q  <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, word index loaded into PC on reset.
REQ-002 Clk  in  1  single clock; all state updates on rising edge.
REQ-003 Clear  in  1  reset, asynchronous, active-low; Clear=0 forces the reset state immediately.
REQ-004 ReadPC  out  32  word address to memory instruction port; bits [31:10] always 0.
REQ-005 MemInstr  in  32  memory instruction word for ReadPC, stable before the next rising edge.
REQ-006 BranchEn  in  1  redirect request from execute stage.
REQ-007 BranchTarget  in  32  redirect word address; only bits [9:0] used.
REQ-008 Ready  in  1  decode stage accepts the head entry this cycle.
REQ-009 Valid  out  1  head entry present.
REQ-010 InstrOut  out  32  head instruction word.
REQ-011 PCOut  out  32  word address of head instruction, bits [31:10]=0.
REQ-012 Halted  out  1  fetch halted (see Configuration).

Function
REQ-013 States: IDLE, RUN, HALT; reset enters IDLE, IDLE->RUN unconditionally after one cycle, no fetch in IDLE.
REQ-014 ReadPC shall equal the PC register combinationally (no extra latency).
REQ-015 2-entry FIFO of {PC, instruction}; Valid = (count != 0); InstrOut/PCOut = head entry, registered.
REQ-016 Fetch in RUN when count<2, or count==2 with Ready=1 that cycle: push {PC, MemInstr}, PC <= PC+1.
REQ-017 No fetch (PC held, MemInstr ignored) when FIFO full and Ready=0.
REQ-018 Pop when Valid=1 and Ready=1; Ready while Valid=0 has no effect.
REQ-019 Simultaneous push and pop with count==1 or 2 shall leave count unchanged and preserve order.
REQ-020 PC increment wraps 10-bit: 1023 -> 0; bits [31:10] never set.
REQ-021 BranchEn=1 has priority over all: FIFO flushed (count<=0), PC <= BranchTarget[9:0], capture that cycle discarded, state <= RUN (from RUN or HALT).
REQ-022 BranchEn with Ready=1 and Valid=1: the head is considered consumed, then flushed.
REQ-023 After a redirect, Valid=0 for exactly one cycle; target instruction appears as head the following cycle.
REQ-024 InstrOut/PCOut shall not change while Valid=1 and Ready=0.

Reset
REQ-025 During and after Clear=0: PC=RESET_PC[9:0], count=0, Valid=0, InstrOut=0, PCOut=0, Halted=0, state=IDLE.
REQ-026 Clear asserted mid-operation shall discard all FIFO contents with no partial output.
REQ-027 Release of Clear takes effect on the first rising edge with Clear=1.

Configuration
REQ-028 Macro FETCH_HALT_EN: when defined, a fetched word equal to 32'hFFFFFFFF is pushed normally and state goes RUN->HALT, fetch stops, PC held at halt address+1, Halted=1 while in HALT; exit only by BranchEn or reset.
REQ-029 Without FETCH_HALT_EN: HALT state absent, 32'hFFFFFFFF is an ordinary word, Halted tied to 0.

Verification
REQ-030 Reset: Clear=0 mid-run with count=2 -> same cycle Valid=0, ReadPC=RESET_PC; after release, first push one cycle after IDLE.
REQ-031 Streaming: mem[0..3]=A,B,C,D, Ready=1 -> heads A,B,C,D with PCOut 0,1,2,3 on consecutive cycles, no bubbles.
REQ-032 Backpressure: Ready=0 for 4 cycles from reset -> count=2, ReadPC holds 2, heads A then B once Ready=1, no loss/duplication.
REQ-033 Redirect: BranchEn=1, BranchTarget=32'h0000_0410 while count=2 -> Valid=0 next cycle, ReadPC=16, then head PCOut=16.
REQ-034 Wrap: redirect to 1022, Ready=1 -> PCOut sequence 1022, 1023, 0, 1.
REQ-035 Halt (FETCH_HALT_EN): mem[2]=32'hFFFFFFFF -> Halted=1, ReadPC frozen at 3, heads 0,1,2 drain; BranchEn to 8 -> Halted=0, fetch resumes at 8.
